// File: rtl/nibble_serial_adder_pkg.sv
// Shared types and constants for the nibble-serial wide adder.
package nibble_serial_adder_pkg;

  localparam int NIBBLE_W = 4;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

endpackage

// File: rtl/adder_slice_4bit.sv
// Combinational 4-bit ripple-carry adder built from chained 1-bit full-adder cells.
module adder_slice_4bit
  import nibble_serial_adder_pkg::*;
(
  input  logic [NIBBLE_W-1:0] x,
  input  logic [NIBBLE_W-1:0] y,
  input  logic                c_in,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c_out
);

  logic [NIBBLE_W:0] carry;

  assign carry[0] = c_in;

  for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
    assign sum[i]       = x[i] ^ y[i] ^ carry[i];
    assign carry[i + 1] = (x[i] & y[i]) | (carry[i] & (x[i] ^ y[i]));
  end

  assign c_out = carry[NIBBLE_W];

endmodule

// File: rtl/nibble_serial_adder.sv
// Handshaked WIDTH-bit adder that reuses one 4-bit slice over WIDTH/4 cycles,
// carrying between nibbles through a register.
module nibble_serial_adder
  import nibble_serial_adder_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int NIB   = WIDTH / NIBBLE_W;
  localparam int CNT_W = (NIB > 1) ? $clog2(NIB) : 1;

  state_t             state;
  state_t             state_next;
  logic [WIDTH-1:0]   a_sh;
  logic [WIDTH-1:0]   b_sh;
  logic [WIDTH-1:0]   sum_q;
  logic               carry_q;
  logic               cout_q;
  logic               drain_q;
  logic [CNT_W-1:0]   cnt;
  logic [NIBBLE_W-1:0] slice_sum;
  logic               slice_cout;
  logic               accept;
  logic               last_nib;

  assign accept   = in_valid & in_ready;
  assign last_nib = (cnt == CNT_W'(NIB - 1));

  adder_slice_4bit u_slice (
    .x     (a_sh[NIBBLE_W-1:0]),
    .y     (b_sh[NIBBLE_W-1:0]),
    .c_in  (carry_q),
    .sum   (slice_sum),
    .c_out (slice_cout)
  );

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: default assignment first so no path leaves state_next unassigned
  // (which would infer a latch).
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = RUN;
      RUN:     if (last_nib) state_next = DONE;
      DONE:    if (out_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // drain_q keeps in_ready low for the cycle right after a result handshake.
  always_comb begin
    in_ready  = (state == IDLE) && !drain_q;
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_sh    <= '0;
      b_sh    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      drain_q <= 1'b0;
      cnt     <= '0;
    end else begin
      drain_q <= (state == DONE) && out_ready;
      unique case (state)
        IDLE: begin
          if (accept) begin
            a_sh    <= a;
            b_sh    <= b;
            carry_q <= cin;
            cnt     <= '0;
            sum_q   <= '0;
          end
        end
        RUN: begin
          sum_q[cnt * NIBBLE_W +: NIBBLE_W] <= slice_sum;
          carry_q <= slice_cout;
          a_sh    <= a_sh >> NIBBLE_W;
          b_sh    <= b_sh >> NIBBLE_W;
          cnt     <= cnt + 1'b1;
          if (last_nib) cout_q <= slice_cout;
        end
        default: ;
      endcase
    end
  end

  assign sum  = sum_q;
  assign cout = cout_q;

endmodule

// File: tb/tb_nibble_serial_adder.sv
// Self-checking bench: directed and random adds on 4-, 16- and 32-bit instances
// against an arithmetic reference model.
module tb_nibble_serial_adder;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] a_w = '0;
  logic [31:0] b_w = '0;
  logic        cin_w = 1'b0;
  logic        iv   [3];
  logic        ordy [3];
  logic        ir   [3];
  logic        ov   [3];
  logic        co   [3];
  logic [31:0] sv   [3];
  logic [3:0]  s4;
  logic [15:0] s16;
  logic [31:0] s32;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  assign sv[0] = {28'd0, s4};
  assign sv[1] = {16'd0, s16};
  assign sv[2] = s32;

  nibble_serial_adder #(.WIDTH(4)) dut4 (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir[0]),
    .a(a_w[3:0]), .b(b_w[3:0]), .cin(cin_w), .out_valid(ov[0]),
    .out_ready(ordy[0]), .sum(s4), .cout(co[0])
  );

  nibble_serial_adder #(.WIDTH(16)) dut16 (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir[1]),
    .a(a_w[15:0]), .b(b_w[15:0]), .cin(cin_w), .out_valid(ov[1]),
    .out_ready(ordy[1]), .sum(s16), .cout(co[1])
  );

  nibble_serial_adder #(.WIDTH(32)) dut32 (
    .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(ir[2]),
    .a(a_w), .b(b_w), .cin(cin_w), .out_valid(ov[2]),
    .out_ready(ordy[2]), .sum(s32), .cout(co[2])
  );

  function automatic int width_of(input int idx);
    return (idx == 0) ? 4 : (idx == 1) ? 16 : 32;
  endfunction

  // Reference: plain unsigned addition in 64-bit arithmetic.
  function automatic void ref_add(input int w, input logic [31:0] x, input logic [31:0] y,
                                  input logic c, output logic [31:0] s, output logic co_o);
    longint unsigned m = (64'd1 << w) - 64'd1;
    longint unsigned t = (longint'(x) & m) + (longint'(y) & m) + longint'(c);
    s    = 32'(t & m);
    co_o = t[w];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready(input int idx);
    int n = 0;
    while (!ir[idx] && n < 100) begin
      tick();
      n++;
    end
    check("ready_timeout", 64'(ir[idx]), 64'd1);
  endtask

  // One handshaked add; stall = cycles out_ready is held low after out_valid.
  task automatic do_op(input int idx, input logic [31:0] x, input logic [31:0] y,
                       input logic c, input int stall);
    int          w = width_of(idx);
    int          edges;
    logic [31:0] es;
    logic        ec;
    ref_add(w, x, y, c, es, ec);
    wait_ready(idx);
    a_w = x; b_w = y; cin_w = c;
    ordy[idx] = (stall == 0);
    iv[idx] = 1'b1;
    tick();
    iv[idx] = 1'b0;
    a_w = $urandom; b_w = $urandom; cin_w = ~c;
    edges = 1;
    check("busy_after_accept", 64'(ir[idx]), 64'd0);
    while (!ov[idx] && edges < 64) begin
      tick();
      edges++;
    end
    check("latency", 64'(edges), 64'(w / 4 + 1));
    check("sum", 64'(sv[idx]), 64'(es));
    check("cout", 64'(co[idx]), 64'(ec));
    for (int i = 0; i < stall; i++) begin
      tick();
      check("held_valid", 64'(ov[idx]), 64'd1);
      check("held_sum", 64'(sv[idx]), 64'(es));
      check("held_cout", 64'(co[idx]), 64'(ec));
      check("held_not_ready", 64'(ir[idx]), 64'd0);
    end
    ordy[idx] = 1'b1;
    tick();
    check("valid_drop", 64'(ov[idx]), 64'd0);
    check("no_bypass", 64'(ir[idx]), 64'd0);
    ordy[idx] = 1'b0;
    tick();
    check("ready_rise", 64'(ir[idx]), 64'd1);
  endtask

  // in_valid held high, out_ready high: three pairs, results and spacing checked.
  task automatic back_to_back(input int idx);
    int          w = width_of(idx);
    logic [31:0] exp_s[$];
    logic        exp_c[$];
    int          acc_t[$];
    int          cyc = 0;
    int          results = 0;
    logic        was_ready, was_valid;
    logic [31:0] es;
    logic        ec;
    wait_ready(idx);
    a_w = $urandom; b_w = $urandom; cin_w = 1'($urandom);
    ordy[idx] = 1'b1;
    iv[idx] = 1'b1;
    while (results < 3 && cyc < 200) begin
      was_ready = ir[idx];
      was_valid = ov[idx];
      tick();
      cyc++;
      if (was_ready && iv[idx]) begin
        ref_add(w, a_w, b_w, cin_w, es, ec);
        exp_s.push_back(es);
        exp_c.push_back(ec);
        acc_t.push_back(cyc);
        if (acc_t.size() < 3) begin
          a_w = $urandom; b_w = $urandom; cin_w = 1'($urandom);
        end else begin
          iv[idx] = 1'b0;
        end
      end
      if (ov[idx] && !was_valid) begin
        results++;
        check("b2b_not_ready", 64'(ir[idx]), 64'd0);
        if (exp_s.size() > 0) begin
          check("b2b_sum", 64'(sv[idx]), 64'(exp_s.pop_front()));
          check("b2b_cout", 64'(co[idx]), 64'(exp_c.pop_front()));
        end else begin
          check("b2b_spurious_result", 64'd1, 64'd0);
        end
      end
    end
    iv[idx] = 1'b0;
    ordy[idx] = 1'b0;
    check("b2b_results", 64'(results), 64'd3);
    check("b2b_accepts", 64'(acc_t.size()), 64'd3);
    for (int i = 1; i < acc_t.size(); i++)
      check("b2b_spacing", 64'(acc_t[i] - acc_t[i-1]), 64'(w / 4 + 3));
    repeat (4) tick();
  endtask

  initial begin
    for (int i = 0; i < 3; i++) begin
      iv[i] = 1'b0;
      ordy[i] = 1'b0;
    end

    // Reset, then idle with in_valid low.
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("rst_in_ready", 64'(ir[i]), 64'd1);
      check("rst_out_valid", 64'(ov[i]), 64'd0);
      check("rst_sum", 64'(sv[i]), 64'd0);
      check("rst_cout", 64'(co[i]), 64'd0);
    end
    repeat (3) tick();
    check("idle_in_ready", 64'(ir[1]), 64'd1);
    check("idle_out_valid", 64'(ov[1]), 64'd0);

    // Directed 16-bit cases.
    do_op(1, 32'h1234, 32'h4321, 1'b0, 0);
    do_op(1, 32'hFFFF, 32'h0000, 1'b1, 0);
    do_op(1, 32'h0FFF, 32'h0001, 1'b0, 0);
    do_op(1, 32'h8000, 32'h8000, 1'b0, 6);

    // Reset on the second RUN cycle discards the operation.
    wait_ready(1);
    a_w = 32'hAAAA; b_w = 32'h5555; cin_w = 1'b0;
    iv[1] = 1'b1;
    tick();
    iv[1] = 1'b0;
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_in_ready", 64'(ir[1]), 64'd1);
    check("midrst_sum", 64'(sv[1]), 64'd0);
    check("midrst_cout", 64'(co[1]), 64'd0);
    for (int i = 0; i < 6; i++) begin
      check("midrst_no_valid", 64'(ov[1]), 64'd0);
      tick();
    end
    do_op(1, 32'h0001, 32'h0001, 1'b0, 0);

    // Boundary cases on the other widths.
    do_op(0, 32'hF, 32'h1, 1'b0, 1);
    do_op(0, 32'hF, 32'hF, 1'b1, 0);
    do_op(2, 32'hFFFF_FFFF, 32'h0, 1'b1, 2);
    do_op(2, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 0);

    // Random operations on every width.
    for (int idx = 0; idx < 3; idx++) begin
      for (int k = 0; k < 6; k++)
        do_op(idx, $urandom, $urandom, 1'($urandom), int'($urandom_range(0, 3)));
    end

    for (int idx = 0; idx < 3; idx++) back_to_back(idx);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
